// File: rtl/pspin_hostmem_rd_burst_splitter.sv
// pspin_hostmem_rd_burst_splitter
//   Accepts one full AXI4 read burst at a time from the host-memory master port
//   and re-issues it downstream as INCR sub-bursts. Each sub-burst is at most
//   MAX_BURST_LEN beats and never crosses a BOUNDARY-byte address boundary.
//   R beats are returned upstream with the original ID and a single RLAST.
//   Unsupported bursts (non-INCR, or beat size wider than the bus) are answered
//   locally with SLVERR beats and nothing is issued downstream.
// Ports
//   clk, rstn        clock, asynchronous active-low reset
//   s_axi_ar*/r*     upstream slave AR/R channels
//   m_axi_ar*/r*     downstream master AR/R channels
//   protocol_err     sticky flag: downstream RLAST disagreed with beat count
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | waiting for an upstream AR
// ISSUE     | downstream AR for the current sub-burst is presented
// WAIT_R    | passing R beats of the current sub-burst upstream
// ERR_RESP  | generating SLVERR beats for an unsupported burst
module pspin_hostmem_rd_burst_splitter #(
    parameter int unsigned ADDR_WIDTH    = 64,
    parameter int unsigned DATA_WIDTH    = 512,
    parameter int unsigned ID_WIDTH      = 8,
    parameter int unsigned ARUSER_WIDTH  = 1,
    parameter int unsigned RUSER_WIDTH   = 1,
    parameter int unsigned MAX_BURST_LEN = 16,
    parameter int unsigned BOUNDARY      = 4096
) (
    input  logic                    clk,
    input  logic                    rstn,

    input  logic [ID_WIDTH-1:0]     s_axi_arid,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [7:0]              s_axi_arlen,
    input  logic [2:0]              s_axi_arsize,
    input  logic [1:0]              s_axi_arburst,
    input  logic [ARUSER_WIDTH-1:0] s_axi_aruser,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,

    output logic [ID_WIDTH-1:0]     s_axi_rid,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rlast,
    output logic [RUSER_WIDTH-1:0]  s_axi_ruser,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready,

    output logic [ID_WIDTH-1:0]     m_axi_arid,
    output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [7:0]              m_axi_arlen,
    output logic [2:0]              m_axi_arsize,
    output logic [1:0]              m_axi_arburst,
    output logic [ARUSER_WIDTH-1:0] m_axi_aruser,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,

    input  logic [ID_WIDTH-1:0]     m_axi_rid,
    input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rlast,
    input  logic [RUSER_WIDTH-1:0]  m_axi_ruser,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready,

    output logic                    protocol_err
);

    localparam int unsigned BEAT_BYTES = DATA_WIDTH / 8;
    localparam logic [1:0]  BURST_INCR = 2'b01;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_R,
        ST_ERR_RESP
    } state_e;

    state_e                  state_q, state_d;
    logic [ID_WIDTH-1:0]     id_q, id_d;
    logic [ARUSER_WIDTH-1:0] user_q, user_d;
    logic [2:0]              size_q, size_d;
    logic [1:0]              burst_q, burst_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [8:0]              rem_q, rem_d;
    logic [8:0]              tot_q, tot_d;
    logic [8:0]              sub_q, sub_d;
    logic [8:0]              sub_cnt_q, sub_cnt_d;
    logic [8:0]              beat_cnt_q, beat_cnt_d;
    logic [ADDR_WIDTH-1:0]   m_araddr_q, m_araddr_d;
    logic [7:0]              m_arlen_q, m_arlen_d;
    logic                    m_arvalid_q, m_arvalid_d;
    logic                    perr_q, perr_d;

    logic [ADDR_WIDTH-1:0]   aligned_addr;
    logic [ADDR_WIDTH-1:0]   next_addr;
    logic [8:0]              next_rem;
    logic [8:0]              new_len;
    logic [8:0]              nsub;
    logic                    sub_last;
    logic                    tot_last;
    logic                    in_wait;
    logic                    in_err;
    logic                    unused_rid;

    // Beats until the next BOUNDARY crossing, capped by remaining beats and MAX_BURST_LEN.
    // The address passed in is always size-aligned, so the result is at least 1.
    function automatic logic [8:0] calc_sub(input logic [ADDR_WIDTH-1:0] a,
                                            input logic [8:0]            r,
                                            input logic [2:0]            sz);
        logic [ADDR_WIDTH-1:0] offs;
        int unsigned           room;
        int unsigned           s;
        offs = a & ADDR_WIDTH'(BOUNDARY - 1);
        room = (BOUNDARY - 32'(offs)) >> sz;
        s    = 32'(r);
        if (MAX_BURST_LEN < s) s = MAX_BURST_LEN;
        if (room < s)          s = room;
        return 9'(s);
    endfunction

    assign in_wait  = (state_q == ST_WAIT_R);
    assign in_err   = (state_q == ST_ERR_RESP);
    assign sub_last = (sub_cnt_q == sub_q - 9'd1);
    assign tot_last = (beat_cnt_q == tot_q - 9'd1);

    always_comb begin
        state_d      = state_q;
        id_d         = id_q;
        user_d       = user_q;
        size_d       = size_q;
        burst_d      = burst_q;
        addr_d       = addr_q;
        rem_d        = rem_q;
        tot_d        = tot_q;
        sub_d        = sub_q;
        sub_cnt_d    = sub_cnt_q;
        beat_cnt_d   = beat_cnt_q;
        m_araddr_d   = m_araddr_q;
        m_arlen_d    = m_arlen_q;
        m_arvalid_d  = m_arvalid_q;
        perr_d       = perr_q;
        aligned_addr = s_axi_araddr & ({ADDR_WIDTH{1'b1}} << s_axi_arsize);
        new_len      = {1'b0, s_axi_arlen} + 9'd1;
        next_addr    = addr_q + (ADDR_WIDTH'(sub_q) << size_q);
        next_rem     = rem_q - sub_q;
        nsub         = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (s_axi_arvalid) begin
                    id_d       = s_axi_arid;
                    user_d     = s_axi_aruser;
                    size_d     = s_axi_arsize;
                    burst_d    = s_axi_arburst;
                    addr_d     = aligned_addr;
                    rem_d      = new_len;
                    tot_d      = new_len;
                    sub_cnt_d  = '0;
                    beat_cnt_d = '0;
                    if (s_axi_arburst != BURST_INCR ||
                        (32'd1 << s_axi_arsize) > BEAT_BYTES) begin
                        state_d = ST_ERR_RESP;
                    end else begin
                        // First downstream AR is loaded here so arvalid rises the next cycle;
                        // it carries the original unaligned address.
                        nsub        = calc_sub(aligned_addr, new_len, s_axi_arsize);
                        sub_d       = nsub;
                        m_araddr_d  = s_axi_araddr;
                        m_arlen_d   = 8'(nsub - 9'd1);
                        m_arvalid_d = 1'b1;
                        state_d     = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (m_axi_arready) begin
                    m_arvalid_d = 1'b0;
                    state_d     = ST_WAIT_R;
                end
            end
            ST_WAIT_R: begin
                if (m_axi_rvalid && s_axi_rready) begin
                    beat_cnt_d = beat_cnt_q + 9'd1;
                    if (m_axi_rlast != sub_last) perr_d = 1'b1;
                    if (sub_last) begin
                        sub_cnt_d = '0;
                        addr_d    = next_addr;
                        rem_d     = next_rem;
                        if (next_rem == 9'd0) begin
                            state_d = ST_IDLE;
                        end else begin
                            nsub        = calc_sub(next_addr, next_rem, size_q);
                            sub_d       = nsub;
                            m_araddr_d  = next_addr;
                            m_arlen_d   = 8'(nsub - 9'd1);
                            m_arvalid_d = 1'b1;
                            state_d     = ST_ISSUE;
                        end
                    end else begin
                        sub_cnt_d = sub_cnt_q + 9'd1;
                    end
                end
            end
            ST_ERR_RESP: begin
                if (s_axi_rready) begin
                    beat_cnt_d = beat_cnt_q + 9'd1;
                    if (tot_last) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            id_q        <= '0;
            user_q      <= '0;
            size_q      <= '0;
            burst_q     <= '0;
            addr_q      <= '0;
            rem_q       <= '0;
            tot_q       <= '0;
            sub_q       <= '0;
            sub_cnt_q   <= '0;
            beat_cnt_q  <= '0;
            m_araddr_q  <= '0;
            m_arlen_q   <= '0;
            m_arvalid_q <= 1'b0;
            perr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            user_q      <= user_d;
            size_q      <= size_d;
            burst_q     <= burst_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            tot_q       <= tot_d;
            sub_q       <= sub_d;
            sub_cnt_q   <= sub_cnt_d;
            beat_cnt_q  <= beat_cnt_d;
            m_araddr_q  <= m_araddr_d;
            m_arlen_q   <= m_arlen_d;
            m_arvalid_q <= m_arvalid_d;
            perr_q      <= perr_d;
        end
    end

    // IDLE is the reset state, so arready is gated with rstn to read 0 during reset.
    assign s_axi_arready = rstn && (state_q == ST_IDLE);

    assign m_axi_arid    = id_q;
    assign m_axi_araddr  = m_araddr_q;
    assign m_axi_arlen   = m_arlen_q;
    assign m_axi_arsize  = size_q;
    assign m_axi_arburst = burst_q;
    assign m_axi_aruser  = user_q;
    assign m_axi_arvalid = m_arvalid_q;

    assign s_axi_rvalid  = (in_wait && m_axi_rvalid) || in_err;
    assign m_axi_rready  = in_wait && s_axi_rready;
    assign s_axi_rid     = id_q;
    assign s_axi_rdata   = in_wait ? m_axi_rdata : '0;
    assign s_axi_rresp   = in_err ? RESP_SLVERR : m_axi_rresp;
    assign s_axi_ruser   = in_wait ? m_axi_ruser : '0;
    assign s_axi_rlast   = (in_wait || in_err) && tot_last;
    assign protocol_err  = perr_q;

    // Downstream RID is not used: the captured upstream ID is returned instead.
    assign unused_rid = ^m_axi_rid;

endmodule

// File: tb/tb_pspin_hostmem_rd_burst_splitter.sv
module tb_pspin_hostmem_rd_burst_splitter;
    localparam int AW = 64;
    localparam int DW = 512;
    localparam int IW = 8;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    logic [IW-1:0] s_axi_arid;
    logic [AW-1:0] s_axi_araddr;
    logic [7:0]    s_axi_arlen;
    logic [2:0]    s_axi_arsize;
    logic [1:0]    s_axi_arburst;
    logic [0:0]    s_axi_aruser;
    logic          s_axi_arvalid;
    logic          s_axi_arready;
    logic [IW-1:0] s_axi_rid;
    logic [DW-1:0] s_axi_rdata;
    logic [1:0]    s_axi_rresp;
    logic          s_axi_rlast;
    logic [0:0]    s_axi_ruser;
    logic          s_axi_rvalid;
    logic          s_axi_rready;
    logic [IW-1:0] m_axi_arid;
    logic [AW-1:0] m_axi_araddr;
    logic [7:0]    m_axi_arlen;
    logic [2:0]    m_axi_arsize;
    logic [1:0]    m_axi_arburst;
    logic [0:0]    m_axi_aruser;
    logic          m_axi_arvalid;
    logic          m_axi_arready;
    logic [IW-1:0] m_axi_rid;
    logic [DW-1:0] m_axi_rdata;
    logic [1:0]    m_axi_rresp;
    logic          m_axi_rlast;
    logic [0:0]    m_axi_ruser;
    logic          m_axi_rvalid;
    logic          m_axi_rready;
    logic          protocol_err;

    pspin_hostmem_rd_burst_splitter dut (
        .clk(clk), .rstn(rstn),
        .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
        .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_aruser(s_axi_aruser),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rlast(s_axi_rlast), .s_axi_ruser(s_axi_ruser), .s_axi_rvalid(s_axi_rvalid),
        .s_axi_rready(s_axi_rready),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_aruser(m_axi_aruser),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rlast(m_axi_rlast), .m_axi_ruser(m_axi_ruser), .m_axi_rvalid(m_axi_rvalid),
        .m_axi_rready(m_axi_rready),
        .protocol_err(protocol_err)
    );

    typedef struct {
        logic [63:0] addr;
        logic [7:0]  len;
        logic [7:0]  id;
        logic [2:0]  size;
        logic        user;
    } ar_t;

    typedef struct {
        logic [7:0]   id;
        logic [511:0] data;
        logic [1:0]   resp;
        logic         last;
        logic         user;
    } r_t;

    ar_t exp_ar[$];
    ar_t resp_q[$];
    r_t  exp_r[$];

    int checks = 0;
    int errors = 0;
    int beat_idx = 0;
    int ar_stall = 0;
    bit rready_toggle = 0;
    bit corrupt_rlast = 0;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Downstream memory content and response are derived from the beat address.
    function automatic logic [511:0] pat(input logic [63:0] a);
        return {8{a ^ 64'hA5A5_0000_0000_0000}};
    endfunction
    function automatic logic [1:0] rsp(input logic [63:0] a);
        return (a == 64'h840) ? 2'b10 : 2'b00;
    endfunction
    function automatic logic [63:0] beat_addr(input logic [63:0] a, input int k, input logic [2:0] sz);
        if (k == 0) return a;
        return (a & (~64'h0 << sz)) + (64'(k) << sz);
    endfunction

    task automatic push_ar(input logic [63:0] a, input logic [7:0] len, input logic [7:0] id,
                           input logic [2:0] sz, input logic user);
        ar_t e;
        e.addr = a; e.len = len; e.id = id; e.size = sz; e.user = user;
        exp_ar.push_back(e);
    endtask

    task automatic push_r(input logic [63:0] a, input int len, input logic [2:0] sz,
                          input logic [7:0] id, input int tot);
        r_t e;
        logic [63:0] ba;
        for (int k = 0; k <= len; k++) begin
            ba = beat_addr(a, k, sz);
            e.id = id; e.data = pat(ba); e.resp = rsp(ba); e.user = ba[6];
            e.last = (beat_idx == tot - 1);
            beat_idx++;
            exp_r.push_back(e);
        end
    endtask

    task automatic push_err(input logic [7:0] id, input int tot);
        r_t e;
        for (int k = 0; k < tot; k++) begin
            e.id = id; e.data = '0; e.resp = 2'b10; e.user = 1'b0; e.last = (k == tot - 1);
            exp_r.push_back(e);
        end
    endtask

    task automatic issue_ar(input logic [7:0] id, input logic [63:0] a, input logic [7:0] len,
                            input logic [2:0] sz, input logic [1:0] burst, input logic user);
        bit hs;
        bit done = 0;
        beat_idx = 0;
        @(posedge clk); #1;
        s_axi_arid = id; s_axi_araddr = a; s_axi_arlen = len; s_axi_arsize = sz;
        s_axi_arburst = burst; s_axi_aruser = user; s_axi_arvalid = 1'b1;
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge clk);
            hs = s_axi_arready;
            @(posedge clk); #1;
            if (hs) done = 1;
        end
        s_axi_arvalid = 1'b0;
        if (!done) begin
            checks++; errors++;
            $display("FAIL ar_handshake: got timeout expected arready");
        end
    endtask

    task automatic wait_done(input string nm);
        bit done = 0;
        for (int n = 0; n < 4000 && !done; n++) begin
            if (exp_r.size() == 0 && exp_ar.size() == 0) done = 1;
            else @(posedge clk);
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL %s: got timeout with %0d beats %0d ARs pending expected 0",
                     nm, exp_r.size(), exp_ar.size());
            exp_r.delete(); exp_ar.delete();
        end
        repeat (3) @(posedge clk);
    endtask

    // R scoreboard monitor
    initial begin
        r_t e;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                if (s_axi_rvalid !== 1'b0) begin
                    checks++; errors++;
                    $display("FAIL rvalid_in_reset: got %0b expected 0", s_axi_rvalid);
                end
            end else if (s_axi_rvalid && s_axi_rready) begin
                if (exp_r.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_r_beat: got beat rdata %0h expected none", s_axi_rdata);
                end else begin
                    e = exp_r.pop_front();
                    chk("r_id", 512'(s_axi_rid), 512'(e.id));
                    chk("r_data", s_axi_rdata, e.data);
                    chk("r_resp", 512'(s_axi_rresp), 512'(e.resp));
                    chk("r_last", 512'(s_axi_rlast), 512'(e.last));
                    chk("r_user", 512'(s_axi_ruser), 512'(e.user));
                end
            end
        end
    end

    // AR scoreboard monitor, also checks field stability while stalled
    initial begin
        ar_t e;
        bit prev_stall = 0;
        logic [63:0] p_addr;
        logic [7:0]  p_len;
        forever begin
            @(negedge clk);
            if (rstn && m_axi_arvalid) begin
                if (prev_stall) begin
                    chk("ar_stable_addr", 512'(m_axi_araddr), 512'(p_addr));
                    chk("ar_stable_len", 512'(m_axi_arlen), 512'(p_len));
                end
                if (m_axi_arready) begin
                    if (exp_ar.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_ar: got addr %0h expected none", m_axi_araddr);
                    end else begin
                        e = exp_ar.pop_front();
                        chk("ar_addr", 512'(m_axi_araddr), 512'(e.addr));
                        chk("ar_len", 512'(m_axi_arlen), 512'(e.len));
                        chk("ar_id", 512'(m_axi_arid), 512'(e.id));
                        chk("ar_size", 512'(m_axi_arsize), 512'(e.size));
                        chk("ar_burst", 512'(m_axi_arburst), 512'(2'b01));
                        chk("ar_user", 512'(m_axi_aruser), 512'(e.user));
                        resp_q.push_back(e);
                    end
                end
            end
            prev_stall = rstn && m_axi_arvalid && !m_axi_arready;
            p_addr = m_axi_araddr;
            p_len  = m_axi_arlen;
        end
    end

    // Downstream R responder
    initial begin
        int  k = 0;
        bit  hs;
        ar_t cur;
        logic [63:0] ba;
        m_axi_rvalid = 0; m_axi_rlast = 0; m_axi_rdata = '0; m_axi_rresp = '0;
        m_axi_ruser = '0; m_axi_rid = 8'hEE;
        forever begin
            @(negedge clk);
            hs = m_axi_rvalid && m_axi_rready;
            @(posedge clk); #1;
            if (!rstn) begin
                resp_q.delete();
                k = 0;
            end else if (hs && resp_q.size() > 0) begin
                k++;
                if (k > int'(resp_q[0].len)) begin
                    void'(resp_q.pop_front());
                    k = 0;
                end
            end
            if (resp_q.size() > 0) begin
                cur = resp_q[0];
                ba = beat_addr(cur.addr, k, cur.size);
                m_axi_rvalid = 1'b1;
                m_axi_rdata  = pat(ba);
                m_axi_rresp  = rsp(ba);
                m_axi_ruser  = ba[6];
                m_axi_rlast  = corrupt_rlast ? (k == 0) : (k == int'(cur.len));
            end else begin
                m_axi_rvalid = 1'b0;
                m_axi_rlast  = 1'b0;
            end
        end
    end

    // Upstream R ready and downstream AR ready drivers
    initial begin
        s_axi_rready = 1'b1;
        forever begin
            @(posedge clk); #1;
            s_axi_rready = rready_toggle ? ~s_axi_rready : 1'b1;
        end
    end

    initial begin
        bit v;
        m_axi_arready = 1'b1;
        forever begin
            @(negedge clk);
            v = m_axi_arvalid;
            @(posedge clk); #1;
            if (ar_stall > 0) begin
                m_axi_arready = 1'b0;
                if (v) ar_stall--;
            end else begin
                m_axi_arready = 1'b1;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0;
        s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = '0;
        s_axi_arburst = '0; s_axi_aruser = '0; s_axi_arvalid = 1'b0;
        #22;
        chk("rst_arready", 512'(s_axi_arready), 512'(0));
        chk("rst_rvalid", 512'(s_axi_rvalid), 512'(0));
        chk("rst_arvalid", 512'(m_axi_arvalid), 512'(0));
        chk("rst_rlast", 512'(s_axi_rlast), 512'(0));
        chk("rst_perr", 512'(protocol_err), 512'(0));
        @(negedge clk); rstn = 1'b1;
        @(negedge clk);
        chk("idle_arready", 512'(s_axi_arready), 512'(1));

        // single sub-burst
        push_ar(64'h1000, 8'd3, 8'h11, 3'd6, 1'b1);
        beat_idx = 0; push_r(64'h1000, 3, 3'd6, 8'h11, 4);
        issue_ar(8'h11, 64'h1000, 8'd3, 3'd6, 2'b01, 1'b1);
        wait_done("t1");

        // split on MAX_BURST_LEN, SLVERR beat at 0x840 passes through
        for (int i = 0; i < 4; i++) push_ar(64'(i * 'h400), 8'd15, 8'h22, 3'd6, 1'b0);
        beat_idx = 0;
        for (int i = 0; i < 4; i++) push_r(64'(i * 'h400), 15, 3'd6, 8'h22, 64);
        issue_ar(8'h22, 64'h0, 8'd63, 3'd6, 2'b01, 1'b0);
        wait_done("t2");

        // split on 4 KiB boundary
        push_ar(64'hFC0, 8'd0, 8'h33, 3'd6, 1'b0);
        push_ar(64'h1000, 8'd2, 8'h33, 3'd6, 1'b0);
        beat_idx = 0;
        push_r(64'hFC0, 0, 3'd6, 8'h33, 4);
        push_r(64'h1000, 2, 3'd6, 8'h33, 4);
        issue_ar(8'h33, 64'hFC0, 8'd3, 3'd6, 2'b01, 1'b0);
        wait_done("t3");

        // unaligned start, 32-byte beats, boundary after the first beat
        push_ar(64'h3FF4, 8'd0, 8'h34, 3'd5, 1'b0);
        push_ar(64'h4000, 8'd2, 8'h34, 3'd5, 1'b0);
        beat_idx = 0;
        push_r(64'h3FF4, 0, 3'd5, 8'h34, 4);
        push_r(64'h4000, 2, 3'd5, 8'h34, 4);
        issue_ar(8'h34, 64'h3FF4, 8'd3, 3'd5, 2'b01, 1'b0);
        wait_done("t3b");

        // FIXED burst answered locally
        push_err(8'h44, 3);
        issue_ar(8'h44, 64'h2000, 8'd2, 3'd6, 2'b00, 1'b1);
        wait_done("t4");
        @(negedge clk);
        chk("arready_after_err", 512'(s_axi_arready), 512'(1));

        // beat wider than the bus answered locally
        push_err(8'h45, 2);
        issue_ar(8'h45, 64'h2000, 8'd1, 3'd7, 2'b01, 1'b0);
        wait_done("t4b");
        chk("perr_clean", 512'(protocol_err), 512'(0));

        // arlen=255: 256 beats as 16 sub-bursts
        for (int i = 0; i < 16; i++) push_ar(64'h10000 + 64'(i * 'h400), 8'd15, 8'h55, 3'd6, 1'b0);
        beat_idx = 0;
        for (int i = 0; i < 16; i++) push_r(64'h10000 + 64'(i * 'h400), 15, 3'd6, 8'h55, 256);
        issue_ar(8'h55, 64'h10000, 8'd255, 3'd6, 2'b01, 1'b0);
        wait_done("t_len256");

        // AR stall, toggling rready, wrong downstream rlast
        ar_stall = 5; rready_toggle = 1; corrupt_rlast = 1;
        push_ar(64'h2000, 8'd7, 8'h66, 3'd6, 1'b0);
        beat_idx = 0; push_r(64'h2000, 7, 3'd6, 8'h66, 8);
        issue_ar(8'h66, 64'h2000, 8'd7, 3'd6, 2'b01, 1'b0);
        wait_done("t5");
        rready_toggle = 0; corrupt_rlast = 0;
        chk("perr_set", 512'(protocol_err), 512'(1));

        // reset in the middle of WAIT_R
        push_ar(64'h5000, 8'd15, 8'h77, 3'd6, 1'b0);
        beat_idx = 0; push_r(64'h5000, 15, 3'd6, 8'h77, 16);
        issue_ar(8'h77, 64'h5000, 8'd15, 3'd6, 2'b01, 1'b0);
        for (int n = 0; n < 200 && exp_r.size() > 12; n++) @(posedge clk);
        chk("t6_midburst", 512'(exp_r.size() <= 12 && exp_r.size() > 0), 512'(1));
        @(negedge clk); #2;
        rstn = 1'b0;
        #1;
        chk("t6_rvalid", 512'(s_axi_rvalid), 512'(0));
        chk("t6_arvalid", 512'(m_axi_arvalid), 512'(0));
        chk("t6_arready", 512'(s_axi_arready), 512'(0));
        chk("t6_rlast", 512'(s_axi_rlast), 512'(0));
        chk("t6_rready", 512'(m_axi_rready), 512'(0));
        chk("t6_perr", 512'(protocol_err), 512'(0));
        exp_r.delete(); exp_ar.delete();
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("t6_arready_after", 512'(s_axi_arready), 512'(1));
        repeat (4) @(negedge clk);
        chk("t6_no_beats", 512'(s_axi_rvalid), 512'(0));

        // normal operation after reset
        push_ar(64'h1000, 8'd3, 8'h88, 3'd6, 1'b0);
        beat_idx = 0; push_r(64'h1000, 3, 3'd6, 8'h88, 4);
        issue_ar(8'h88, 64'h1000, 8'd3, 3'd6, 2'b01, 1'b0);
        wait_done("t7");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
